alu_arb: RTL

- Shares the single combinational ALU between NREQ requesters, such as the fetch/PC-increment path, the execute stage and the debug port.
- Arbitrates requests round-robin and registers the operands presented to the ALU.
- Captures the ALU result and flags, then returns them to the granted requester over a valid/ready response channel.
- Sits between the requesters and the ALU. This block is the only driver of the ALU operand and op inputs.

---
 rtl/pico.sv | 25 ++
 rtl/alu_arb.sv | 130 +++++++++++++
 2 files changed

// File: rtl/pico.sv
// rtl/pico.sv - shared datapath width, ALU opcode and flag types
package pico;

    localparam int N = 8;

    typedef enum logic [2:0] {
        F_ADD = 3'd0,
        F_SUB = 3'd1,
        F_AND = 3'd2,
        F_OR  = 3'd3,
        F_XOR = 3'd4,
        F_NOT = 3'd5,
        F_SHL = 3'd6,
        F_SHR = 3'd7
    } funcALU;

    // Carry, Overflow, Zero, Negative (carry is the MSB of the packed word)
    typedef struct packed {
        logic c;
        logic v;
        logic z;
        logic n;
    } flagsALU;

endpackage

// File: rtl/alu_arb.sv
// rtl/alu_arb.sv - round-robin arbiter sharing one combinational ALU; optional ALU_ARB_LOCK_EN
module alu_arb
    import pico::*;
#(
    parameter int NREQ = 2
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [NREQ-1:0]     req_valid_i,
    output logic [NREQ-1:0]     req_ready_o,
    input  funcALU              req_op_i [NREQ],
    input  logic signed [N-1:0] req_a_i  [NREQ],
    input  logic signed [N-1:0] req_b_i  [NREQ],
    output logic [NREQ-1:0]     rsp_valid_o,
    input  logic [NREQ-1:0]     rsp_ready_i,
    output logic [N-1:0]        rsp_r_o,
    output flagsALU             rsp_flags_o,
    output logic [N-1:0]        alu_a_o,
    output logic [N-1:0]        alu_b_o,
    output funcALU              alu_op_o,
    input  logic [N-1:0]        alu_r_i,
    input  flagsALU             alu_flags_i,
`ifdef ALU_ARB_LOCK_EN
    input  logic [NREQ-1:0]     req_lock_i,
`endif
    output logic                busy_o
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t         r_state;
    logic [PW-1:0]  r_ptr;
    logic [PW-1:0]  r_owner;
    logic [N-1:0]   r_alu_a;
    logic [N-1:0]   r_alu_b;
    funcALU         r_alu_op;
    logic [N-1:0]   r_rsp_r;
    flagsALU        r_rsp_flags;

    logic           w_found;
    logic [PW-1:0]  w_winner;
    logic [PW-1:0]  w_owner_inc;
    logic [PW-1:0]  w_ptr_next;

    // Winner search: first valid requester starting at the pointer, wrapping modulo NREQ
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (!w_found && req_valid_i[(int'(r_ptr) + i) % NREQ]) begin
                w_found  = 1'b1;
                w_winner = PW'((int'(r_ptr) + i) % NREQ);
            end
        end
    end

    // Pointer after completion: next requester, or the same one while it holds its lock
    always_comb begin
        w_owner_inc = (r_owner == PW'(NREQ - 1)) ? '0 : r_owner + 1'b1;
`ifdef ALU_ARB_LOCK_EN
        w_ptr_next  = req_lock_i[r_owner] ? r_owner : w_owner_inc;
`else
        w_ptr_next  = w_owner_inc;
`endif
    end

    // Handshake decode: grant only in IDLE, response only to the owner in RESP
    always_comb begin
        req_ready_o = '0;
        rsp_valid_o = '0;
        if (r_state == S_IDLE && w_found) begin
            req_ready_o[w_winner] = 1'b1;
        end
        if (r_state == S_RESP) begin
            rsp_valid_o[r_owner] = 1'b1;
        end
    end

    // Sequencer: latch operands on grant, capture ALU output one cycle later, hold until accepted
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= S_IDLE;
            r_ptr       <= '0;
            r_owner     <= '0;
            r_alu_a     <= '0;
            r_alu_b     <= '0;
            r_alu_op    <= F_ADD;
            r_rsp_r     <= '0;
            r_rsp_flags <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_alu_a  <= req_a_i[w_winner];
                        r_alu_b  <= req_b_i[w_winner];
                        r_alu_op <= req_op_i[w_winner];
                        r_owner  <= w_winner;
                        r_state  <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    r_rsp_r     <= alu_r_i;
                    r_rsp_flags <= alu_flags_i;
                    r_state     <= S_RESP;
                end
                S_RESP: begin
                    if (rsp_ready_i[r_owner]) begin
                        r_ptr   <= w_ptr_next;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign alu_a_o     = r_alu_a;
    assign alu_b_o     = r_alu_b;
    assign alu_op_o    = r_alu_op;
    assign rsp_r_o     = r_rsp_r;
    assign rsp_flags_o = r_rsp_flags;
    assign busy_o      = (r_state != S_IDLE);

endmodule
